// File: rtl/wash_cycle_timer.sv
// Plant-side water-level and phase-timer model that closes the loop around the washer controller.
// Optional `pause` input enabled by defining WASH_TIMER_PAUSE_EN.
module wash_cycle_timer #(
  parameter int unsigned LEVEL_W     = 8,
  parameter int unsigned FULL_LEVEL  = 20,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WASH_CYCLES = 50,
  parameter int unsigned SPIN_CYCLES = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               motor_on,
  input  logic               fill_valve,
  input  logic               drain_valve,
  input  logic               door_lock,
  output logic               water_full,
  output logic               water_drained,
  output logic               wash_timeout,
  output logic               spin_timeout,
  output logic               door_fault,
  output logic [LEVEL_W-1:0] level
`ifdef WASH_TIMER_PAUSE_EN
  ,
  input  logic               pause
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WASH     = 3'd1;
  localparam logic [2:0] WASH_EXP = 3'd2;
  localparam logic [2:0] SPIN     = 3'd3;
  localparam logic [2:0] SPIN_EXP = 3'd4;

  localparam logic [LEVEL_W-1:0] FULL_LVL  = LEVEL_W'(FULL_LEVEL);
  localparam logic [CNT_W-1:0]   WASH_LAST = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SPIN_LAST = CNT_W'(SPIN_CYCLES - 1);

  logic               hold;
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               full_q;
  logic               wash_to_q, wash_to_d;
  logic               spin_to_q, spin_to_d;
  logic               fault_q, fault_d;
  logic               drain_prev_q;
  logic               drain_rise;

`ifdef WASH_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign drain_rise = drain_valve & ~drain_prev_q;

  always_comb begin
    level_d = level_q;
    if (!hold) begin
      if (fill_valve && !drain_valve && (level_q != '1)) begin
        level_d = level_q + 1'b1;
      end else if (drain_valve && !fill_valve && (level_q != '0)) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wash_to_d = wash_to_q;
    spin_to_d = spin_to_q;
    fault_d   = fault_q;
    // Door fault and motor-off override everything, including pause.
    if (motor_on && !door_lock) begin
      state_d   = IDLE;
      cnt_d     = '0;
      wash_to_d = 1'b0;
      spin_to_d = 1'b0;
      fault_d   = 1'b1;
    end else if (!motor_on) begin
      state_d   = IDLE;
      cnt_d     = '0;
      wash_to_d = 1'b0;
      spin_to_d = 1'b0;
    end else if (!hold) begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = drain_valve ? SPIN : WASH;
        end
        WASH, WASH_EXP: begin
          if (drain_rise) begin
            state_d   = SPIN;
            cnt_d     = '0;
            wash_to_d = 1'b0;
          end else if (state_q == WASH) begin
            if (cnt_q == WASH_LAST) begin
              state_d   = WASH_EXP;
              wash_to_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        SPIN: begin
          if (cnt_q == SPIN_LAST) begin
            state_d   = SPIN_EXP;
            spin_to_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SPIN_EXP: ;
        default: begin
          state_d   = IDLE;
          cnt_d     = '0;
          wash_to_d = 1'b0;
          spin_to_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      wash_to_q    <= 1'b0;
      spin_to_q    <= 1'b0;
      fault_q      <= 1'b0;
      drain_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      full_q       <= (level_d >= FULL_LVL);
      wash_to_q    <= wash_to_d;
      spin_to_q    <= spin_to_d;
      fault_q      <= fault_d;
      drain_prev_q <= drain_valve;
    end
  end

  assign level         = level_q;
  assign water_full    = full_q;
  assign water_drained = (level_q == '0);
  assign wash_timeout  = wash_to_q;
  assign spin_timeout  = spin_to_q;
  assign door_fault    = fault_q;

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Directed bench for wash_cycle_timer: vector table for the main phase flow plus hand sequences
// for fill/drain saturation, single-cycle wash, asynchronous reset and (optionally) pause.
module tb_wash_cycle_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       motor_on, fill_valve, drain_valve, door_lock, pause;
  logic       water_full, water_drained, wash_timeout, spin_timeout, door_fault;
  logic [7:0] level;
  logic       full1, drained1, wto1, sto1, fault1;
  logic [7:0] level1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wash_cycle_timer #(
    .LEVEL_W(8), .FULL_LEVEL(20), .CNT_W(16), .WASH_CYCLES(4), .SPIN_CYCLES(3)
  ) u_dut (
    .clk(clk), .reset(reset), .motor_on(motor_on), .fill_valve(fill_valve),
    .drain_valve(drain_valve), .door_lock(door_lock), .water_full(water_full),
    .water_drained(water_drained), .wash_timeout(wash_timeout), .spin_timeout(spin_timeout),
    .door_fault(door_fault), .level(level)
`ifdef WASH_TIMER_PAUSE_EN
    , .pause(pause)
`endif
  );

  // Second instance exercises the single-cycle wash boundary.
  wash_cycle_timer #(
    .LEVEL_W(8), .FULL_LEVEL(20), .CNT_W(16), .WASH_CYCLES(1), .SPIN_CYCLES(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .motor_on(motor_on), .fill_valve(fill_valve),
    .drain_valve(drain_valve), .door_lock(door_lock), .water_full(full1),
    .water_drained(drained1), .wash_timeout(wto1), .spin_timeout(sto1),
    .door_fault(fault1), .level(level1)
`ifdef WASH_TIMER_PAUSE_EN
    , .pause(pause)
`endif
  );

  typedef struct {
    logic m, f, d, l;
    logic full, drained, wto, sto, flt;
    logic [7:0] lvl;
  } vec_t;

  vec_t vecs[30];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic m, input logic f, input logic d, input logic l);
    @(negedge clk);
    motor_on    = m;
    fill_valve  = f;
    drain_valve = d;
    door_lock   = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    motor_on    = 1'b0;
    fill_valve  = 1'b0;
    drain_valve = 1'b0;
    door_lock   = 1'b0;
    pause       = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] in, input logic [4:0] outs, input logic [7:0] lvl);
    vec_t v;
    {v.m, v.f, v.d, v.l} = in;
    {v.full, v.drained, v.wto, v.sto, v.flt} = outs;
    v.lvl = lvl;
    return v;
  endfunction

  initial begin
    // inputs {motor, fill, drain, lock}; outputs {full, drained, wash_to, spin_to, fault}
    vecs[0]  = mk(4'b0000, 5'b01000, 8'd0);
    vecs[1]  = mk(4'b0100, 5'b00000, 8'd1);
    vecs[2]  = mk(4'b0100, 5'b00000, 8'd2);
    vecs[3]  = mk(4'b0100, 5'b00000, 8'd3);
    vecs[4]  = mk(4'b1001, 5'b00000, 8'd3);  // E: enter wash
    vecs[5]  = mk(4'b1001, 5'b00000, 8'd3);
    vecs[6]  = mk(4'b1001, 5'b00000, 8'd3);
    vecs[7]  = mk(4'b1001, 5'b00000, 8'd3);
    vecs[8]  = mk(4'b1001, 5'b00100, 8'd3);  // E+4
    vecs[9]  = mk(4'b1001, 5'b00100, 8'd3);
    vecs[10] = mk(4'b1011, 5'b00000, 8'd2);  // F: drain rises -> spin
    vecs[11] = mk(4'b1011, 5'b00000, 8'd1);
    vecs[12] = mk(4'b1011, 5'b01000, 8'd0);
    vecs[13] = mk(4'b1011, 5'b01010, 8'd0);  // F+3
    vecs[14] = mk(4'b1001, 5'b01010, 8'd0);  // drain fall ignored
    vecs[15] = mk(4'b0001, 5'b01000, 8'd0);
    vecs[16] = mk(4'b1001, 5'b01000, 8'd0);
    vecs[17] = mk(4'b1001, 5'b01000, 8'd0);
    vecs[18] = mk(4'b1001, 5'b01000, 8'd0);
    vecs[19] = mk(4'b1001, 5'b01000, 8'd0);
    vecs[20] = mk(4'b1001, 5'b01100, 8'd0);
    vecs[21] = mk(4'b0001, 5'b01000, 8'd0);  // motor off clears
    vecs[22] = mk(4'b1000, 5'b01001, 8'd0);  // door fault
    vecs[23] = mk(4'b1001, 5'b01001, 8'd0);  // fault left FSM idle: fresh entry
    vecs[24] = mk(4'b1001, 5'b01001, 8'd0);
    vecs[25] = mk(4'b1001, 5'b01001, 8'd0);
    vecs[26] = mk(4'b1001, 5'b01001, 8'd0);
    vecs[27] = mk(4'b1001, 5'b01101, 8'd0);
    vecs[28] = mk(4'b1000, 5'b01001, 8'd0);  // fault in WASH_EXP clears timeout
    vecs[29] = mk(4'b0000, 5'b01001, 8'd0);

    reset = 1'b1; motor_on = 1'b0; fill_valve = 1'b0; drain_valve = 1'b0;
    door_lock = 1'b0; pause = 1'b0;
    #2;
    check("rst_level", 32'(level), 0);
    check("rst_drained", 32'(water_drained), 1);
    check("rst_outs", 32'({water_full, wash_timeout, spin_timeout, door_fault}), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      step(vecs[i].m, vecs[i].f, vecs[i].d, vecs[i].l);
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d_flags", i),
            32'({water_full, water_drained, wash_timeout, spin_timeout, door_fault}),
            32'({vecs[i].full, vecs[i].drained, vecs[i].wto, vecs[i].sto, vecs[i].flt}));
    end

    // Fill to full and saturation.
    do_reset();
    for (int k = 1; k <= 257; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 19 || k == 20) begin
        check($sformatf("fill%0d_level", k), 32'(level), 32'(k));
        check($sformatf("fill%0d_full", k), 32'(water_full), (k >= 20) ? 1 : 0);
      end
      if (k >= 255) check($sformatf("fill%0d_sat", k), 32'(level), 255);
    end

    // Drain from 3 with saturation at 0.
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("drain%0d_level", k), 32'(level), (k >= 3) ? 0 : 32'(3 - k));
      check($sformatf("drain%0d_drained", k), 32'(water_drained), (k >= 3) ? 1 : 0);
    end

    // WASH_CYCLES = 1: timeout at E+1.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("w1_entry", 32'(wto1), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("w1_timeout", 32'(wto1), 1);
    check("w4_not_yet", 32'(wash_timeout), 0);

    // Door fault, then asynchronous reset in SPIN_EXP.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("fault_set", 32'(door_fault), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 1'b1);
    check("pre_rst_spin_to", 32'(spin_timeout), 1);
    check("pre_rst_level", 32'(level), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_level", 32'(level), 0);
    check("async_drained", 32'(water_drained), 1);
    check("async_outs", 32'({water_full, wash_timeout, spin_timeout, door_fault}), 0);
    @(negedge clk);
    reset = 1'b0;

`ifdef WASH_TIMER_PAUSE_EN
    // Five paused edges inside WASH push the timeout from E+4 to E+9.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    pause = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("pause_e8", 32'(wash_timeout), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("pause_e9", 32'(wash_timeout), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
